// File: rtl/ctl_trace_pkg.sv
// Shared types and constants for the control-word trace buffer.
package ctl_trace_pkg;

  // Default field widths of one trace entry; they match the packed st_ctl
  // word and the free-running capture timestamp.
  localparam int TRACE_CTL_W = 67;
  localparam int TRACE_TS_W  = 16;

  // Bit position of the sync (opcode fetch) flag inside the packed st_ctl word.
  localparam int CTL_SYNC_BIT = 0;

  // Capture FSM; the encoding is visible on the state port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // One stored entry. The RAM word is packed in this same field order:
  // {ctl, ts, trig}.
  typedef struct packed {
    logic [TRACE_CTL_W-1:0] ctl;
    logic [TRACE_TS_W-1:0]  ts;
    logic                   trig;
  } trace_entry_t;

endpackage

// File: rtl/ctl_trace_ram.sv
// Simple dual-port trace memory: one write port, one registered read port.
module ctl_trace_ram #(
  parameter int W     = 84,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Write port: one entry per enabled cycle, contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: data appears the cycle after the address is presented.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ctl_trace.sv
// Trace capture buffer for the CPU control word: circular pre-trigger
// history, trigger compare, post-trigger count, oldest-first read-out.
module ctl_trace
  import ctl_trace_pkg::*;
#(
  parameter int CTL_W = TRACE_CTL_W,
  parameter int DEPTH = 64,
  parameter int TS_W  = TRACE_TS_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CTL_W-1:0] ctl,
  input  logic             ctl_en,
  input  logic             arm,
  input  logic             mode,
  input  logic [CTL_W-1:0] trig_mask,
  input  logic [CTL_W-1:0] trig_val,
  input  logic [AW:0]      post_cnt,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CTL_W-1:0] rd_ctl,
  output logic [TS_W-1:0]  rd_ts,
  output logic             rd_trig,
  output logic [1:0]       state,
  output logic [AW:0]      count
);

  localparam int          EW      = CTL_W + TS_W + 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // A post count of zero still keeps the trigger entry; more than the
  // buffer can hold is limited to a full buffer.
  function automatic logic [AW:0] clamp_post(input logic [AW:0] p);
    if (p == '0)     return (AW+1)'(1);
    if (p > DEPTH_C) return DEPTH_C;
    return p;
  endfunction

  // Capture control
  trace_state_e   state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [AW:0]    rem_q, rem_d;
  logic [AW:0]    issue_left_q, issue_left_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic           enter_done;

  // Read-out pipeline: RAM output stage, skid slot, output register
  logic           ram_vld_q, ram_vld_d;
  logic           skid_vld_q, skid_vld_d;
  logic [EW-1:0]  skid_q, skid_d;
  logic           out_vld_q, out_vld_d;
  logic [EW-1:0]  out_q, out_d;

  logic           qual;
  logic           hit;
  logic           wr_en;
  logic [EW-1:0]  wr_data;
  logic           pop;
  logic [1:0]     occ;
  logic           rd_en;
  logic [EW-1:0]  ram_rdata;

  assign qual    = ctl_en && (!mode || ctl[CTL_SYNC_BIT]);
  assign hit     = ((ctl ^ trig_val) & trig_mask) == '0;
  assign wr_en   = !arm && qual && (state_q == ST_ARMED || state_q == ST_TRIG);
  // Only the first hit, seen while still armed, is flagged.
  assign wr_data = {ctl, ts_q, hit && (state_q == ST_ARMED)};
  assign pop     = out_vld_q && rd_ready;

  // Entries that will still sit in the output/skid slots after this edge,
  // counting the one arriving from the RAM. A new read is issued only when
  // its data is sure to find a free slot even if the consumer then stalls.
  assign occ   = 2'(ram_vld_q) + 2'(skid_vld_q) + 2'(out_vld_q) - 2'(pop);
  assign rd_en = !arm && (state_q == ST_DONE) && (issue_left_q != '0) && (occ < 2'd2);

  ctl_trace_ram #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Capture FSM, write pointer, occupancy, timestamp and read issue pointer.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rem_d        = rem_q;
    ts_d         = ts_q;
    issue_left_d = issue_left_q;
    enter_done   = 1'b0;
    if (arm) begin
      state_d      = ST_ARMED;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      rem_d        = '0;
      ts_d         = '0;
      issue_left_d = '0;
    end else begin
      case (state_q)
        ST_ARMED, ST_TRIG: begin
          if (ctl_en) ts_d = ts_q + 1'b1;
          if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != DEPTH_C) count_d = count_q + 1'b1;
            if (state_q == ST_ARMED) begin
              if (hit) begin
                rem_d = clamp_post(post_cnt) - 1'b1;
                if (rem_d == '0) enter_done = 1'b1;
                else             state_d    = ST_TRIG;
              end
            end else begin
              rem_d = rem_q - 1'b1;
              if (rem_d == '0) enter_done = 1'b1;
            end
          end
          // Oldest entry sits count entries behind the write pointer; a
          // full buffer wraps that back onto the write pointer itself.
          if (enter_done) begin
            state_d      = ST_DONE;
            issue_left_d = count_d;
            rd_ptr_d     = wr_ptr_d - count_d[AW-1:0];
          end
        end
        ST_DONE: begin
          if (rd_en) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            issue_left_d = issue_left_q - 1'b1;
          end
          if (pop) begin
            count_d = count_q - 1'b1;
            if (count_d == '0) state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Output register refills from the skid slot first so order is kept;
  // RAM data goes to the skid slot while the consumer stalls.
  always_comb begin
    ram_vld_d  = rd_en;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    if (arm) begin
      skid_vld_d = 1'b0;
      out_vld_d  = 1'b0;
      out_d      = '0;
    end else if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_d     = ram_rdata;
        skid_vld_d = ram_vld_q;
      end else if (ram_vld_q) begin
        out_d     = ram_rdata;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (ram_vld_q) begin
      skid_d     = ram_rdata;
      skid_vld_d = 1'b1;
    end
  end

  // Control state and the visible output register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rem_q        <= '0;
      ts_q         <= '0;
      issue_left_q <= '0;
      ram_vld_q    <= 1'b0;
      skid_vld_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rem_q        <= rem_d;
      ts_q         <= ts_d;
      issue_left_q <= issue_left_d;
      ram_vld_q    <= ram_vld_d;
      skid_vld_q   <= skid_vld_d;
      out_vld_q    <= out_vld_d;
      out_q        <= out_d;
    end
  end

  // Skid payload is qualified by skid_vld_q and needs no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign rd_valid                  = out_vld_q;
  assign {rd_ctl, rd_ts, rd_trig}  = out_q;
  assign state                     = state_q;
  assign count                     = count_q;

endmodule

// File: tb/tb_ctl_trace.sv
// Self-checking bench for ctl_trace against a list-based capture model.
module tb_ctl_trace;
  import ctl_trace_pkg::*;

  localparam int CW = 67;
  localparam int TW = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] ctl = '0;
  logic          ctl_en = 1'b0;
  logic          arm = 1'b0;
  logic          mode = 1'b0;
  logic [CW-1:0] trig_mask = '0;
  logic [CW-1:0] trig_val = '0;
  logic [AW:0]   post_cnt = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [CW-1:0] rd_ctl;
  logic [TW-1:0] rd_ts;
  logic          rd_trig;
  logic [1:0]    state;
  logic [AW:0]   count;

  ctl_trace #(.CTL_W(CW), .DEPTH(D), .TS_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .ctl(ctl), .ctl_en(ctl_en), .arm(arm),
    .mode(mode), .trig_mask(trig_mask), .trig_val(trig_val),
    .post_cnt(post_cnt), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_ctl(rd_ctl), .rd_ts(rd_ts), .rd_trig(rd_trig),
    .state(state), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [TW-1:0] ts;
    logic          trig;
  } ent_t;

  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] c_a [64];
  bit            en_a [64];
  int            n;
  ent_t          exp_q [$];
  int            t_done, t_vld;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rnd_ctl(input int idx);
    logic [CW-1:0] v;
    logic [7:0]    tag;
    v = {3'($urandom), $urandom, $urandom};
    tag = idx[7:0];
    v[CW-1:CW-8] = tag;
    return v;
  endfunction

  // sync_every > 0 sets the sync bit only on every sync_every-th cycle.
  task automatic fill(input int nn, input int sync_every, input int en_pct);
    n = nn;
    for (int i = 0; i < nn; i++) begin
      c_a[i] = rnd_ctl(i);
      if (sync_every > 0) c_a[i][CTL_SYNC_BIT] = (i % sync_every) == 0;
      en_a[i] = $urandom_range(0, 99) < en_pct;
    end
  endtask

  function automatic int clampp(input int p);
    if (p == 0) return 1;
    if (p > D) return D;
    return p;
  endfunction

  // Model: list every qualified cycle with its CPU-cycle index as ts,
  // flag the first hit, stop after clamp(post) entries from the hit,
  // and keep the newest D entries.
  function automatic void build_model(input bit md, input logic [CW-1:0] mask,
                                      input logic [CW-1:0] val, input int post);
    ent_t hist [$];
    ent_t e;
    int   ts = 0;
    int   need = -1;
    bit   seen = 0;
    int   start;
    for (int i = 0; i < n; i++) begin
      if (need == 0) break;
      if (en_a[i]) begin
        if (!md || c_a[i][CTL_SYNC_BIT]) begin
          e.c = c_a[i];
          e.ts = TW'(ts);
          e.trig = 1'b0;
          if (!seen && ((c_a[i] ^ val) & mask) == '0) begin
            seen = 1;
            e.trig = 1'b1;
            need = clampp(post);
          end
          hist.push_back(e);
          if (seen) need--;
        end
        ts++;
      end
    end
    exp_q.delete();
    start = (hist.size() > D) ? hist.size() - D : 0;
    for (int i = start; i < hist.size(); i++) exp_q.push_back(hist[i]);
  endfunction

  task automatic do_capture(input bit md, input logic [CW-1:0] mask,
                            input logic [CW-1:0] val, input int post, input bit arm_hot);
    int t = 0;
    t_done = -1;
    t_vld = -1;
    mode = md;
    trig_mask = mask;
    trig_val = val;
    post_cnt = (AW+1)'(post);
    rd_ready = 1'b0;
    arm = 1'b1;
    ctl_en = arm_hot;
    ctl = arm_hot ? val : '0;
    step();
    t++;
    arm = 1'b0;
    for (int i = 0; i < n + 4; i++) begin
      if (i < n) begin
        ctl = c_a[i];
        ctl_en = en_a[i];
      end else begin
        ctl_en = 1'b0;
      end
      step();
      t++;
      if (t_done < 0 && state == 2'd3) t_done = t;
      if (t_vld < 0 && rd_valid) t_vld = t;
    end
    build_model(md, mask, val, post);
  endtask

  task automatic drain(input string name, input int pct);
    int   got = 0;
    int   cyc = 0;
    int   first = -1;
    int   last = -1;
    bit   stalled = 0;
    ent_t held, obs;
    held = '0;
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL %s done_state: got %0d want 3", name, state);
    end
    checks++;
    if (count !== (AW+1)'(exp_q.size())) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d", name, count, exp_q.size());
    end
    while (got < exp_q.size() && cyc < 400) begin
      rd_ready = $urandom_range(0, 99) < pct;
      obs = {rd_ctl, rd_ts, rd_trig};
      if (stalled) begin
        checks++;
        if (!rd_valid || obs !== held) begin
          errors++;
          $display("FAIL %s hold: got vld=%0b ts=%0d want vld=1 ts=%0d", name, rd_valid, obs.ts, held.ts);
        end
      end
      if (rd_valid) begin
        if (rd_ready) begin
          checks++;
          if (obs !== exp_q[got]) begin
            errors++;
            $display("FAIL %s entry%0d: got ctl=%h ts=%0d trig=%0b want ctl=%h ts=%0d trig=%0b",
                     name, got, obs.c, obs.ts, obs.trig, exp_q[got].c, exp_q[got].ts, exp_q[got].trig);
          end
          if (first < 0) first = cyc;
          last = cyc;
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = obs;
        end
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    checks++;
    if (got != exp_q.size()) begin
      errors++;
      $display("FAIL %s entries_read: got %0d want %0d (cycle budget)", name, got, exp_q.size());
    end
    checks++;
    if (rd_valid !== 1'b0 || state !== 2'd0 || count !== '0) begin
      errors++;
      $display("FAIL %s end: got vld=%0b state=%0d count=%0d want 0/0/0", name, rd_valid, state, count);
    end
    if (pct == 100) begin
      checks++;
      if (last - first != exp_q.size() - 1) begin
        errors++;
        $display("FAIL %s throughput: got %0d cycles want %0d", name, last - first, exp_q.size() - 1);
      end
    end
  endtask

  task automatic check_latency(input string name);
    checks++;
    if (t_done < 0 || t_vld - t_done != 2) begin
      errors++;
      $display("FAIL %s latency: got done@%0d vld@%0d want vld 2 after done", name, t_done, t_vld);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0 ||
        rd_ctl !== '0 || rd_ts !== '0 || rd_trig !== 1'b0) begin
      errors++;
      $display("FAIL %s: got state=%0d count=%0d vld=%0b ctl=%h ts=%0d trig=%0b want all 0",
               name, state, count, rd_valid, rd_ctl, rd_ts, rd_trig);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    ctl_en = 1'b1;
    step();
    step();
    ctl_en = 1'b0;
    checks++;
    if (state !== 2'd0 || count !== '0) begin
      errors++;
      $display("FAIL idle_no_write: got state=%0d count=%0d want 0/0", state, count);
    end
  endtask

  task automatic test_no_wrap();
    fill(10, 0, 100);
    do_capture(0, '0, '0, 3, 0);
    check_latency("no_wrap");
    drain("no_wrap", 100);
  endtask

  task automatic test_prewrap();
    fill(20, 0, 100);
    do_capture(0, '1, c_a[12], 2, 0);
    check_latency("prewrap");
    drain("prewrap", 100);
  endtask

  task automatic test_sync_mode();
    fill(30, 3, 100);
    do_capture(1, '0, '0, 8, 0);
    drain("sync_mode", 100);
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] m;
    for (int k = 0; k < 3; k++) begin
      fill(40, 0, 75);
      for (int i = 15; i < 40; i++) en_a[i] = 1;
      m = rnd_ctl(0) & rnd_ctl(1);
      do_capture(0, m, c_a[15], $urandom_range(1, 8), 0);
      drain("backpressure", 50);
    end
  endtask

  task automatic test_back_to_back();
    fill(24, 0, 100);
    do_capture(0, '1, c_a[20], 4, 0);
    drain("back_to_back", 100);
  endtask

  task automatic test_post_limits();
    fill(6, 0, 100);
    do_capture(0, '0, '0, 0, 0);
    drain("post_zero", 100);
    fill(20, 0, 100);
    do_capture(0, '0, '0, 15, 0);
    drain("post_big", 60);
  endtask

  task automatic test_arm_qual();
    fill(10, 0, 100);
    do_capture(0, '1, c_a[5], 2, 1);
    drain("arm_qual", 100);
  endtask

  task automatic test_arm_in_done();
    fill(10, 0, 100);
    do_capture(0, '0, '0, 5, 0);
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL arm_done_pre: got vld=%0b want 1", rd_valid);
    end
    arm = 1'b1;
    step();
    arm = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || state !== 2'd1 || count !== '0) begin
      errors++;
      $display("FAIL arm_done: got vld=%0b state=%0d count=%0d want 0/1/0", rd_valid, state, count);
    end
    rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || state !== 2'd1) begin
      errors++;
      $display("FAIL arm_done_flush: got vld=%0b state=%0d want 0/1", rd_valid, state);
    end
  endtask

  task automatic test_reset_mid();
    fill(10, 0, 100);
    mode = 1'b0;
    trig_mask = '1;
    trig_val = c_a[2];
    post_cnt = 4'd8;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ctl = c_a[i];
      ctl_en = 1'b1;
      step();
    end
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_pre: got state=%0d want 2", state);
    end
    rst_n = 1'b0;
    step();
    check_reset_outputs("reset_in_trig");
    rst_n = 1'b1;
    step();
    step();
    ctl_en = 1'b0;
    checks++;
    if (state !== 2'd0 || count !== '0) begin
      errors++;
      $display("FAIL reset_mid_idle: got state=%0d count=%0d want 0/0", state, count);
    end
    // Reset while an entry is on the output port.
    fill(10, 0, 100);
    do_capture(0, '0, '0, 4, 0);
    rst_n = 1'b0;
    step();
    check_reset_outputs("reset_in_done");
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_no_wrap();
    test_prewrap();
    test_sync_mode();
    test_backpressure();
    test_back_to_back();
    test_post_limits();
    test_arm_qual();
    test_arm_in_done();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
